// File: rtl/weighted_pkt_rr_arbiter.sv
// Weighted round-robin N:1 valid/ready arbiter with packet locking.
// Each grant carries a credit equal to the requester's weight, counted in packets or beats.
module weighted_pkt_rr_arbiter #(
   parameter int unsigned REQ_NUM  = 8,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned WEIGHT_W = 4,
   parameter int unsigned USE_LAST = 1,
   parameter int unsigned ID_W     = $clog2(REQ_NUM)
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [REQ_NUM-1:0]          valid_in,
   input  logic [REQ_NUM*DATA_W-1:0]   payload_in,
   input  logic [REQ_NUM-1:0]          last_in,
   input  logic [REQ_NUM*WEIGHT_W-1:0] weight_in,
   input  logic                        ready_out,
   output logic [REQ_NUM-1:0]          ready_in,
   output logic                        valid_out,
   output logic [DATA_W-1:0]           payload_out,
   output logic                        last_out,
   output logic [ID_W-1:0]             grant_id
);

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_LOCKED = 1'b1;

   logic                st_q, st_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     gnt_q, gnt_d;
   logic [WEIGHT_W-1:0] credit_q, credit_d;
   logic                in_pkt_q, in_pkt_d;

   logic [DATA_W-1:0]   pay_arr [REQ_NUM];
   logic [WEIGHT_W-1:0] wgt_arr [REQ_NUM];

   logic                any_valid;
   logic [ID_W-1:0]     scan_idx;
   logic [ID_W-1:0]     sel;
   logic                sel_valid;
   logic [WEIGHT_W-1:0] sel_weight;
   logic [WEIGHT_W-1:0] weff;
   logic                fire;
   logic                dec;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
      if (32'(x) == REQ_NUM - 1) return '0;
      return x + ID_W'(1);
   endfunction

   for (genvar g = 0; g < REQ_NUM; g++) begin : g_unpack
      assign pay_arr[g] = payload_in[g*DATA_W +: DATA_W];
      assign wgt_arr[g] = weight_in[g*WEIGHT_W +: WEIGHT_W];
   end

   // Rotating priority scan starting at ptr_q.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      any_valid = 1'b0;
      scan_idx  = ptr_q;
      for (int unsigned k = 0; k < REQ_NUM; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= REQ_NUM) idx = idx - REQ_NUM;
         if (!any_valid && valid_in[idx[ID_W-1:0]]) begin
            any_valid = 1'b1;
            scan_idx  = idx[ID_W-1:0];
         end
      end
   end

   // Outputs are gated by rstn so an asynchronous reset clears them immediately.
   always_comb begin
      sel         = (st_q == ST_LOCKED) ? gnt_q : scan_idx;
      sel_valid   = (st_q == ST_LOCKED) ? valid_in[gnt_q] : any_valid;
      valid_out   = rstn & sel_valid;
      ready_in    = '0;
      if (rstn) ready_in[sel] = ready_out;
      payload_out = valid_out ? pay_arr[sel] : '0;
      last_out    = valid_out & last_in[sel];
      grant_id    = rstn ? sel : '0;
      fire        = valid_out & ready_out;
      dec         = (USE_LAST != 0) ? (fire & last_in[sel]) : fire;
      sel_weight  = wgt_arr[sel];
      weff        = (sel_weight == '0) ? WEIGHT_W'(1) : sel_weight;
   end

   always_comb begin
      st_d     = st_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      credit_d = credit_q;
      in_pkt_d = in_pkt_q;
      if (fire && (USE_LAST != 0)) in_pkt_d = !last_in[sel];
      if (st_q == ST_IDLE) begin
         if (any_valid) begin
            // A stalled first beat must still lock so the selection stays put.
            if (dec && (weff == WEIGHT_W'(1))) begin
               ptr_d    = wrap_inc(sel);
               in_pkt_d = 1'b0;
            end else begin
               st_d     = ST_LOCKED;
               gnt_d    = sel;
               credit_d = weff - WEIGHT_W'(dec);
            end
         end
      end else begin
         if (dec && (credit_q == WEIGHT_W'(1))) begin
            st_d     = ST_IDLE;
            ptr_d    = wrap_inc(gnt_q);
            credit_d = '0;
            in_pkt_d = 1'b0;
         end else if (dec) begin
            credit_d = credit_q - WEIGHT_W'(1);
         end else if (!valid_in[gnt_q] && !in_pkt_q) begin
            st_d     = ST_IDLE;
            ptr_d    = wrap_inc(gnt_q);
            credit_d = '0;
            in_pkt_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_q     <= ST_IDLE;
         ptr_q    <= '0;
         gnt_q    <= '0;
         credit_q <= '0;
         in_pkt_q <= 1'b0;
      end else begin
         st_q     <= st_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         credit_q <= credit_d;
         in_pkt_q <= in_pkt_d;
      end
   end

endmodule

// File: tb/tb_weighted_pkt_rr_arbiter.sv
// Bench for weighted_pkt_rr_arbiter: packet-mode and beat-mode instances share stimulus
// and are compared every cycle against an owner/credit reference model.
module tb_weighted_pkt_rr_arbiter;
   localparam int N  = 8;
   localparam int DW = 32;
   localparam int WW = 4;

   logic clk = 1'b0;
   logic rstn;
   logic [N-1:0]    valid_in, last_in;
   logic [N*DW-1:0] payload_in;
   logic [N*WW-1:0] weight_in;
   logic            ready_out;

   logic [N-1:0]  ready_in_p, ready_in_b;
   logic          valid_out_p, valid_out_b, last_out_p, last_out_b;
   logic [DW-1:0] payload_out_p, payload_out_b;
   logic [2:0]    grant_id_p, grant_id_b;

   int n_checks = 0;
   int n_errors = 0;

   // model state, index 0 = packet mode, 1 = beat mode; owner -1 means no grant held
   int m_owner[2];
   int m_start[2];
   int m_cred[2];
   bit m_mid[2];

   logic [N-1:0]  fired_p;
   logic [2:0]    snap_id_p, snap_id_b;
   logic          snap_valid_p, snap_valid_b;
   logic [DW-1:0] snap_pay_p;
   logic [N-1:0]  snap_ready_p;
   bit            bc[N];

   always #5 clk = ~clk;

   weighted_pkt_rr_arbiter #(.REQ_NUM(N), .DATA_W(DW), .WEIGHT_W(WW), .USE_LAST(1)) u_dut_pkt (
      .clk(clk), .rstn(rstn), .valid_in(valid_in), .payload_in(payload_in), .last_in(last_in),
      .weight_in(weight_in), .ready_out(ready_out), .ready_in(ready_in_p), .valid_out(valid_out_p),
      .payload_out(payload_out_p), .last_out(last_out_p), .grant_id(grant_id_p));

   weighted_pkt_rr_arbiter #(.REQ_NUM(N), .DATA_W(DW), .WEIGHT_W(WW), .USE_LAST(0)) u_dut_beat (
      .clk(clk), .rstn(rstn), .valid_in(valid_in), .payload_in(payload_in), .last_in(last_in),
      .weight_in(weight_in), .ready_out(ready_out), .ready_in(ready_in_b), .valid_out(valid_out_b),
      .payload_out(payload_out_b), .last_out(last_out_b), .grant_id(grant_id_b));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_weight(input int i, input logic [WW-1:0] w);
      weight_in[i*WW +: WW] = w;
   endtask

   task automatic set_pay(input int i, input logic [DW-1:0] p);
      payload_in[i*DW +: DW] = p;
   endtask

   function automatic int scan_from(input int s);
      for (int k = 0; k < N; k++) begin
         if (valid_in[(s + k) % N]) return (s + k) % N;
      end
      return -1;
   endfunction

   task automatic model_cycle(input int m);
      logic [N-1:0]  g_ready, e_ready;
      logic          g_valid, g_last;
      logic [DW-1:0] g_pay;
      logic [2:0]    g_id;
      logic [WW-1:0] w;
      int            s;
      bit            v, fire, pkt_end;
      string         sfx;
      sfx     = (m == 0) ? "pkt" : "beat";
      g_ready = (m == 0) ? ready_in_p : ready_in_b;
      g_valid = (m == 0) ? valid_out_p : valid_out_b;
      g_last  = (m == 0) ? last_out_p : last_out_b;
      g_pay   = (m == 0) ? payload_out_p : payload_out_b;
      g_id    = (m == 0) ? grant_id_p : grant_id_b;
      if (!rstn) begin
         check_eq({"rst_valid_", sfx}, g_valid, 0);
         check_eq({"rst_ready_", sfx}, g_ready, 0);
         check_eq({"rst_payload_", sfx}, g_pay, 0);
         check_eq({"rst_last_", sfx}, g_last, 0);
         check_eq({"rst_grant_", sfx}, g_id, 0);
         m_owner[m] = -1;
         m_start[m] = 0;
         m_cred[m]  = 0;
         m_mid[m]   = 1'b0;
         return;
      end
      s = (m_owner[m] >= 0) ? m_owner[m] : scan_from(m_start[m]);
      v = (s >= 0) && valid_in[s];
      check_eq({"valid_", sfx}, g_valid, v);
      if (v) begin
         e_ready    = '0;
         e_ready[s] = ready_out;
         check_eq({"payload_", sfx}, g_pay, payload_in[s*DW +: DW]);
         check_eq({"last_", sfx}, g_last, last_in[s]);
         check_eq({"grant_", sfx}, g_id, s);
         check_eq({"ready_", sfx}, g_ready, e_ready);
      end else begin
         check_eq({"idle_payload_", sfx}, g_pay, 0);
         check_eq({"idle_last_", sfx}, g_last, 0);
      end
      if (s < 0) return;
      fire    = v && ready_out;
      pkt_end = (m == 0) ? last_in[s] : 1'b1;
      if (m_owner[m] < 0) begin
         w          = weight_in[s*WW +: WW];
         m_owner[m] = s;
         m_cred[m]  = (w == 0) ? 1 : int'(w);
      end
      if (fire) begin
         if (m == 0) m_mid[m] = !last_in[s];
         if (pkt_end) m_cred[m]--;
      end
      if (m_cred[m] == 0 || (!valid_in[s] && !m_mid[m])) begin
         m_owner[m] = -1;
         m_start[m] = (s + 1) % N;
         m_mid[m]   = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      fired_p      = valid_in & ready_in_p;
      snap_id_p    = grant_id_p;
      snap_id_b    = grant_id_b;
      snap_valid_p = valid_out_p;
      snap_valid_b = valid_out_b;
      snap_pay_p   = payload_out_p;
      snap_ready_p = ready_in_p;
      model_cycle(0);
      model_cycle(1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
   endtask

   task automatic all_weights(input logic [WW-1:0] w);
      for (int i = 0; i < N; i++) set_weight(i, w);
   endtask

   initial begin
      rstn      = 1'b0;
      valid_in  = '1;
      last_in   = '0;
      ready_out = 1'b1;
      for (int i = 0; i < N; i++) set_pay(i, $urandom);
      all_weights(4'd1);
      #1;
      step();
      step();
      check_eq("rst_hold_ready", snap_ready_p, 0);
      check_eq("rst_hold_valid", snap_valid_p, 0);
      rstn = 1'b1;
      step();
      check_eq("first_grant_p", snap_id_p, 0);
      check_eq("first_grant_b", snap_id_b, 0);

      // plain round robin in beat mode
      valid_in = '1;
      last_in  = '0;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step();
         check_eq("rr_seq_b", snap_id_b, i % 8);
         check_eq("rr_valid_b", snap_valid_b, 1);
      end

      // weight 3 vs 1 with 2-beat packets
      valid_in = 8'b0000_0011;
      set_weight(0, 4'd3);
      bc[0] = 1'b0;
      bc[1] = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         last_in    = '0;
         last_in[0] = bc[0];
         last_in[1] = bc[1];
         step();
         check_eq("wgt_seq_p", snap_id_p, (i < 6) ? 0 : ((i < 8) ? 1 : 0));
         for (int r = 0; r < 2; r++) if (fired_p[r]) bc[r] = !bc[r];
      end

      // backpressure holds selection and payload
      all_weights(4'd1);
      valid_in  = 8'b0000_0100;
      last_in   = '1;
      set_pay(2, 32'hA5A5A5A5);
      ready_out = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (i == 2) valid_in[1] = 1'b1;
         step();
         check_eq("stall_grant_p", snap_id_p, 2);
         check_eq("stall_payload_p", snap_pay_p, 32'hA5A5A5A5);
         check_eq("stall_valid_p", snap_valid_p, 1);
      end
      ready_out = 1'b1;
      step();
      check_eq("stall_fire_grant_p", snap_id_p, 2);
      check_eq("stall_fire_ready_p", snap_ready_p, 8'b0000_0100);
      valid_in[2] = 1'b0;
      step();
      check_eq("after_stall_grant_p", snap_id_p, 1);

      // mid-packet lock while owner drops valid
      valid_in = 8'b0000_1001;
      last_in  = '0;
      do_reset();
      step();
      check_eq("lock_first_grant_p", snap_id_p, 0);
      valid_in[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("lock_ready3_p", snap_ready_p[3], 0);
         check_eq("lock_valid_p", snap_valid_p, 0);
      end
      valid_in[0] = 1'b1;
      step();
      check_eq("lock_beat2_ready3_p", snap_ready_p[3], 0);
      last_in[0] = 1'b1;
      step();
      check_eq("lock_last_ready_p", snap_ready_p, 8'b0000_0001);
      valid_in[0] = 1'b0;
      last_in     = '0;
      step();
      check_eq("lock_next_grant_p", snap_id_p, 3);
      check_eq("lock_next_ready_p", snap_ready_p, 8'b0000_1000);

      // early release at a packet boundary with credit left
      set_weight(0, 4'd2);
      valid_in = 8'b0000_0001;
      last_in  = 8'b0000_0001;
      do_reset();
      step();
      check_eq("rel_fire_grant_p", snap_id_p, 0);
      valid_in = 8'b0000_1000;
      step();
      check_eq("rel_gap_valid_p", snap_valid_p, 0);
      step();
      check_eq("rel_grant_p", snap_id_p, 3);
      check_eq("rel_valid_p", snap_valid_p, 1);

      // weight 0 behaves as one packet per grant
      all_weights(4'd1);
      set_weight(5, 4'd0);
      valid_in = 8'b0110_0000;
      bc[5]    = 1'b0;
      bc[6]    = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         last_in    = '0;
         last_in[5] = bc[5];
         last_in[6] = bc[6];
         step();
         check_eq("w0_seq_p", snap_id_p, ((i / 2) % 2 == 0) ? 5 : 6);
         for (int r = 5; r < 7; r++) if (fired_p[r]) bc[r] = !bc[r];
      end

      // asynchronous reset in the middle of a packet
      valid_in = 8'b0010_0000;
      last_in  = '0;
      do_reset();
      step();
      valid_in = 8'b0110_0000;
      #1;
      rstn = 1'b0;
      #1;
      check_eq("async_rst_valid_p", valid_out_p, 0);
      check_eq("async_rst_grant_p", grant_id_p, 0);
      check_eq("async_rst_ready_p", ready_in_p, 0);
      check_eq("async_rst_payload_p", payload_out_p, 0);
      step();
      rstn = 1'b1;
      step();
      check_eq("post_rst_grant_p", snap_id_p, 5);

      // randomized traffic
      for (int i = 0; i < N; i++) set_weight(i, WW'($urandom_range(0, 4)));
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            valid_in[i] = ($urandom_range(0, 99) < 65);
            last_in[i]  = ($urandom_range(0, 99) < 40);
            set_pay(i, $urandom);
         end
         ready_out = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 49) == 0) set_weight($urandom_range(0, N - 1), WW'($urandom_range(0, 15)));
         rstn = ($urandom_range(0, 999) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
